// File: rtl/seq_piso_feeder.sv
// Parallel-in/serial-out feeder with a one-word holding register for gap-free streaming.
// Optional even-parity trailer bit per word enabled by defining SEQ_PISO_PARITY_EN.
module seq_piso_feeder #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             out,
  output logic             out_valid,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
`ifdef SEQ_PISO_PARITY_EN
  localparam logic [CW-1:0] LAST = CW'(WIDTH);
`else
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
`endif

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             out_valid_q, out_valid_d;
`ifdef SEQ_PISO_PARITY_EN
  logic             par_q, par_d;
`endif

  logic             accept;
  logic             ld;
  logic [WIDTH-1:0] ld_word;

  function automatic logic lead_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], IDLE_BIT} : {IDLE_BIT, w[WIDTH-1:1]};
  endfunction

  assign load_ready = !hold_full_q;
  assign accept     = load_valid && load_ready;
  assign out        = out_q;
  assign out_valid  = out_valid_q;
  assign busy       = (state_q == SHIFT) || hold_full_q;

  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
`ifdef SEQ_PISO_PARITY_EN
    par_d       = par_q;
`endif
    ld          = 1'b0;
    ld_word     = data_in;

    case (state_q)
      IDLE: begin
        if (accept) ld = 1'b1;
      end
      SHIFT: begin
        if (cnt_q == LAST) begin
          // Frame end: refill from hold first, else bypass a word arriving this edge.
          if (hold_full_q) begin
            ld          = 1'b1;
            ld_word     = hold_q;
            hold_full_d = 1'b0;
          end else if (accept) begin
            ld = 1'b1;
          end else begin
            state_d = IDLE;
            out_d   = IDLE_BIT;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
`ifdef SEQ_PISO_PARITY_EN
          if (cnt_q == CW'(WIDTH - 1)) begin
            out_d = par_q;
          end else begin
            out_d = lead_bit(sh_q);
            sh_d  = shift_word(sh_q);
          end
`else
          out_d = lead_bit(sh_q);
          sh_d  = shift_word(sh_q);
`endif
          if (accept) begin
            hold_d      = data_in;
            hold_full_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (ld) begin
      state_d = SHIFT;
      cnt_d   = '0;
      out_d   = lead_bit(ld_word);
      sh_d    = shift_word(ld_word);
`ifdef SEQ_PISO_PARITY_EN
      par_d   = ^ld_word;
`endif
    end

    out_valid_d = (state_d == SHIFT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      sh_q        <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      cnt_q       <= '0;
      out_q       <= IDLE_BIT;
      out_valid_q <= 1'b0;
`ifdef SEQ_PISO_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
`ifdef SEQ_PISO_PARITY_EN
      par_q       <= par_d;
`endif
    end
  end

endmodule
